sparse_subtractor64_pipe: RTL and testbench

//  Pipelined WIDTH-bit subtractor: DIFF = A - B - BIN, with borrow-out BO and signed overflow OV.

---
 rtl/sparse_arith_pkg.sv | 21 ++
 rtl/sparse_carry_tree.sv | 48 ++++
 rtl/sparse_subtractor64_pipe.sv | 116 +++++++++++
 tb/tb_sparse_subtractor64_pipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_arith_pkg.sv
// Shared constants and prefix-combine helper for the sparse-tree adder/subtractor family.
package sparse_arith_pkg;

    localparam int unsigned WIDTH_DEFAULT    = 64;
    localparam int unsigned SPARSITY_DEFAULT = 4;
    localparam int unsigned NBLK             = WIDTH_DEFAULT / SPARSITY_DEFAULT;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Combine a more-significant (hi) group with a less-significant (lo) group.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/sparse_carry_tree.sv
// Sparse prefix carry tree: produces the carry into every SPARSITY-bit block plus carry-out.
module sparse_carry_tree
    import sparse_arith_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEFAULT,
    parameter int unsigned SPARSITY = SPARSITY_DEFAULT
) (
    input  logic [WIDTH-1:0]          g,
    input  logic [WIDTH-1:0]          p,
    input  logic                      cin,
    output logic [WIDTH/SPARSITY:0]   blk_carry
);

    localparam int unsigned NB = WIDTH / SPARSITY;

    gp_t blk_gp [NB];
    gp_t pre    [NB];
    gp_t lvl    [NB];

    always_comb begin
        for (int unsigned k = 0; k < NB; k++) begin
            blk_gp[k] = gp_t'({g[k*SPARSITY], p[k*SPARSITY]});
            for (int unsigned j = 1; j < SPARSITY; j++) begin
                blk_gp[k] = gp_combine(gp_t'({g[k*SPARSITY+j], p[k*SPARSITY+j]}), blk_gp[k]);
            end
        end
    end

    // Kogge-Stone prefix over block groups; pre[k] spans blocks k..0.
    always_comb begin
        pre = blk_gp;
        lvl = blk_gp;
        for (int unsigned d = 1; d < NB; d = d * 2) begin
            lvl = pre;
            for (int unsigned i = d; i < NB; i++) begin
                pre[i] = gp_combine(lvl[i], lvl[i-d]);
            end
        end
    end

    always_comb begin
        blk_carry[0] = cin;
        for (int unsigned k = 0; k < NB; k++) begin
            blk_carry[k+1] = pre[k].g | (pre[k].p & cin);
        end
    end

endmodule

// File: rtl/sparse_subtractor64_pipe.sv
// Two-stage valid/ready pipelined subtractor: DIFF = A - B - BIN via A + ~B + ~BIN on a
// sparse carry tree (stage 1) and carry-select block sums (stage 2).
module sparse_subtractor64_pipe
    import sparse_arith_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEFAULT,
    parameter int unsigned SPARSITY = SPARSITY_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] DIFF,
    output logic             BO,
    output logic             OV
);

    localparam int unsigned NB = WIDTH / SPARSITY;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [NB:0]      blk_c;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NB:0]      s1_c;
    logic             s1_a_msb;
    logic             s1_b_msb;

    logic             s2_adv;
    logic [WIDTH-1:0] sum0;
    logic [WIDTH-1:0] sum1;
    logic [WIDTH-1:0] diff_d;
    logic             ov_d;
    logic             c0;
    logic             c1;

    assign p = A ^ ~B;
    assign g = A & ~B;

    sparse_carry_tree #(
        .WIDTH    (WIDTH),
        .SPARSITY (SPARSITY)
    ) u_carry_tree (
        .g         (g),
        .p         (p),
        .cin       (~BIN),
        .blk_carry (blk_c)
    );

    assign s2_adv   = s1_valid & (~OUT_VALID | OUT_READY);
    assign IN_READY = ~s1_valid | s2_adv;

    // Block-local ripple is needed for both carry-in cases, hence G is kept alongside P.
    always_comb begin
        sum0   = '0;
        sum1   = '0;
        diff_d = '0;
        c0     = 1'b0;
        c1     = 1'b1;
        for (int unsigned k = 0; k < NB; k++) begin
            c0 = 1'b0;
            c1 = 1'b1;
            for (int unsigned j = 0; j < SPARSITY; j++) begin
                sum0[k*SPARSITY+j] = s1_p[k*SPARSITY+j] ^ c0;
                sum1[k*SPARSITY+j] = s1_p[k*SPARSITY+j] ^ c1;
                c0 = s1_g[k*SPARSITY+j] | (s1_p[k*SPARSITY+j] & c0);
                c1 = s1_g[k*SPARSITY+j] | (s1_p[k*SPARSITY+j] & c1);
            end
            diff_d[k*SPARSITY +: SPARSITY] = s1_c[k] ? sum1[k*SPARSITY +: SPARSITY]
                                                     : sum0[k*SPARSITY +: SPARSITY];
        end
        ov_d = (s1_a_msb ^ s1_b_msb) & (s1_a_msb ^ diff_d[WIDTH-1]);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_valid  <= 1'b0;
            s1_p      <= '0;
            s1_g      <= '0;
            s1_c      <= '0;
            s1_a_msb  <= 1'b0;
            s1_b_msb  <= 1'b0;
            OUT_VALID <= 1'b0;
            DIFF      <= '0;
            BO        <= 1'b0;
            OV        <= 1'b0;
        end else begin
            if (IN_READY) begin
                s1_valid <= IN_VALID;
                if (IN_VALID) begin
                    s1_p     <= p;
                    s1_g     <= g;
                    s1_c     <= blk_c;
                    s1_a_msb <= A[WIDTH-1];
                    s1_b_msb <= B[WIDTH-1];
                end
            end
            if (s2_adv) begin
                OUT_VALID <= 1'b1;
                DIFF      <= diff_d;
                BO        <= ~s1_c[NB];
                OV        <= ov_d;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sparse_subtractor64_pipe.sv
// Directed-vector, back-pressure, reset and random-scoreboard bench for sparse_subtractor64_pipe.
module tb_sparse_subtractor64_pipe;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic        BIN = 1'b0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [63:0] DIFF;
    logic        BO;
    logic        OV;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    sparse_subtractor64_pipe dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .BIN       (BIN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .DIFF      (DIFF),
        .BO        (BO),
        .OV        (OV)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [63:0] diff;
        logic        bo;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [63:0] diff;
        logic        bo;
        logic        ov;
    } exp_t;

    localparam int NVEC = 10;
    localparam int NRAND = 2000;
    vec_t vecs [NVEC];
    exp_t q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        @(posedge CLK); #1;
        A = vecs[i].a;
        B = vecs[i].b;
        BIN = vecs[i].bin;
        IN_VALID = 1'b1;
        OUT_READY = 1'b1;
        #1;
        check($sformatf("v%0d_in_ready", i), IN_READY, 1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        check($sformatf("v%0d_not_early", i), OUT_VALID, 0);
        @(posedge CLK); #1;
        check($sformatf("v%0d_out_valid", i), OUT_VALID, 1);
        check($sformatf("v%0d_diff", i), DIFF, vecs[i].diff);
        check($sformatf("v%0d_bo", i), BO, vecs[i].bo);
        check($sformatf("v%0d_ov", i), OV, vecs[i].ov);
        @(posedge CLK); #1;
        check($sformatf("v%0d_valid_drop", i), OUT_VALID, 0);
    endtask

    initial begin
        logic        pend;
        int          sent;
        int          recv;
        int          cyc;
        logic [64:0] s;
        exp_t        e;

        vecs[0] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0};
        vecs[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
        vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0, 1'b0, 1'b0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                    64'h8000_0000_0000_0000, 1'b1, 1'b1};
        vecs[7] = '{64'h10, 64'h1, 1'b1, 64'hE, 1'b0, 1'b0};
        vecs[8] = '{64'h1_0000_0000, 64'd1, 1'b0, 64'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[9] = '{64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_diff", DIFF, 0);
        check("rst_bo", BO, 0);
        check("rst_ov", OV, 0);
        check("rst_in_ready", IN_READY, 1);

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Back-pressure: only two sets fit, third waits until the consumer is ready
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        A = 64'd100; B = 64'd1; BIN = 1'b0; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        A = 64'd50; B = 64'd60; BIN = 1'b0;
        @(posedge CLK); #1;
        A = 64'd7; B = 64'd7; BIN = 1'b1;
        #1;
        check("bp_in_ready_low", IN_READY, 0);
        check("bp_out_valid", OUT_VALID, 1);
        check("bp_diff_first", DIFF, 64'd99);
        repeat (3) @(posedge CLK);
        #1;
        check("bp_diff_stable", DIFF, 64'd99);
        check("bp_bo_stable", BO, 0);
        check("bp_in_ready_still_low", IN_READY, 0);
        OUT_READY = 1'b1;
        #1;
        check("bp_in_ready_release", IN_READY, 1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        check("bp_second_valid", OUT_VALID, 1);
        check("bp_second_diff", DIFF, 64'hFFFF_FFFF_FFFF_FFF6);
        check("bp_second_bo", BO, 1);
        @(posedge CLK); #1;
        check("bp_third_valid", OUT_VALID, 1);
        check("bp_third_diff", DIFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("bp_third_bo", BO, 1);
        @(posedge CLK); #1;
        check("bp_drained", OUT_VALID, 0);

        // Reset with two operations in flight
        OUT_READY = 1'b0;
        A = 64'd9; B = 64'd4; BIN = 1'b0; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        A = 64'd8; B = 64'd2;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        check("fl_full_valid", OUT_VALID, 1);
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        check("fl_rst_out_valid", OUT_VALID, 0);
        check("fl_rst_diff", DIFF, 0);
        check("fl_rst_in_ready", IN_READY, 1);
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            check($sformatf("fl_no_stale_%0d", i), OUT_VALID, 0);
        end

        // Random stream against an arithmetic scoreboard
        pend = 1'b0;
        sent = 0;
        recv = 0;
        cyc = 0;
        while (recv < NRAND && cyc < 20000) begin
            @(posedge CLK); #1;
            cyc++;
            if (!pend) begin
                if (sent < NRAND && $urandom_range(3) != 0) begin
                    A = {$urandom, $urandom};
                    B = ($urandom_range(15) == 0) ? A : {$urandom, $urandom};
                    BIN = 1'($urandom_range(1));
                    IN_VALID = 1'b1;
                end else begin
                    IN_VALID = 1'b0;
                end
            end
            OUT_READY = ($urandom_range(2) != 0);
            #1;
            if (IN_VALID && IN_READY) begin
                s = {1'b0, A} + {1'b0, ~B} + 65'(!BIN);
                e.diff = s[63:0];
                e.bo = ~s[64];
                e.ov = (A[63] ^ B[63]) & (A[63] ^ s[63]);
                q.push_back(e);
                sent++;
                pend = 1'b0;
            end else begin
                pend = IN_VALID;
            end
            if (OUT_VALID && OUT_READY) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_unexpected: got result %h expected none", DIFF);
                end else begin
                    e = q.pop_front();
                    check($sformatf("rand%0d_diff", recv), DIFF, e.diff);
                    check($sformatf("rand%0d_bo", recv), BO, e.bo);
                    check($sformatf("rand%0d_ov", recv), OV, e.ov);
                end
                recv++;
            end
        end
        IN_VALID = 1'b0;
        check("rand_received", 64'(recv), 64'(NRAND));
        check("rand_queue_empty", 64'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
